// File: rtl/dcache_stall_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_stall_ctrl
// Data-cache miss controller for a 5-stage pipeline. Detects a MEM-stage miss,
// optionally writes back the dirty victim, refills the line from main memory,
// strobes the refill into the cache and freezes the pipeline for the duration.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   start_i       CPU run enable; gates acceptance of new misses only
//   mem_req_i     MEM stage holds a valid load/store
//   hit_i         data-cache tag hit for the MEM-stage address
//   dirty_i       victim line dirty, sampled in IDLE on a miss
//   mem_ack_i     main memory completed the current transaction
//   stall_o       pipeline freeze (Mealy in IDLE, 1 in every busy state)
//   mem_enable_o  main-memory request valid
//   mem_write_o   1 = victim write-back, 0 = line read
//   refill_o      one-cycle strobe to write the fetched line into the cache
//   busy_o        FSM not in IDLE
//   miss_cnt_o    accepted misses, saturating at all-ones
//   stall_cyc_o   cycles with stall_o=1, wrapping
// -----------------------------------------------------------------------------
module dcache_stall_ctrl #(
  parameter int unsigned MISS_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mem_req_i,
  input  logic                  hit_i,
  input  logic                  dirty_i,
  input  logic                  mem_ack_i,
  output logic                  stall_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic                  refill_o,
  output logic                  busy_o,
  output logic [MISS_CNT_W-1:0] miss_cnt_o,
  output logic [31:0]           stall_cyc_o
);

  localparam int unsigned CYC_W = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2,
    S_COMMIT    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  w_miss;
  logic                  w_stall;

  logic                  r_mem_enable;
  logic                  r_mem_write;
  logic                  r_refill;
  logic                  r_busy;
  logic                  w_nxt_mem_enable;
  logic                  w_nxt_mem_write;
  logic                  w_nxt_refill;
  logic                  w_nxt_busy;

  logic [MISS_CNT_W-1:0] r_miss_cnt;
  logic [CYC_W-1:0]      r_stall_cyc;

  // Miss qualification: only IDLE accepts a new miss, and only while running.
  assign w_miss  = (r_state == S_IDLE) & start_i & mem_req_i & ~hit_i;

  // Stall must be combinational on the detecting cycle so the pipeline
  // registers do not advance past the missing access.
  assign w_stall = (r_state != S_IDLE) | w_miss;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_next = dirty_i ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        // Going straight to REFILL keeps mem_enable_o high with no gap.
        if (mem_ack_i) begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          w_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the next state so their registers always
  // mirror a decode of the current state.
  always_comb begin
    w_nxt_mem_enable = 1'b0;
    w_nxt_mem_write  = 1'b0;
    w_nxt_refill     = 1'b0;
    w_nxt_busy       = 1'b0;
    unique case (w_next)
      S_IDLE: begin
        w_nxt_busy = 1'b0;
      end
      S_WRITEBACK: begin
        w_nxt_mem_enable = 1'b1;
        w_nxt_mem_write  = 1'b1;
        w_nxt_busy       = 1'b1;
      end
      S_REFILL: begin
        w_nxt_mem_enable = 1'b1;
        w_nxt_busy       = 1'b1;
      end
      S_COMMIT: begin
        w_nxt_refill = 1'b1;
        w_nxt_busy   = 1'b1;
      end
      default: begin
        w_nxt_busy = 1'b0;
      end
    endcase
  end

  // State and registered Moore outputs; reset wins over any in-flight miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_refill     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_mem_enable <= w_nxt_mem_enable;
      r_mem_write  <= w_nxt_mem_write;
      r_refill     <= w_nxt_refill;
      r_busy       <= w_nxt_busy;
    end
  end

  // Accepted-miss counter, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_miss_cnt <= '0;
    end else if (w_miss && (r_miss_cnt != {MISS_CNT_W{1'b1}})) begin
      r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
    end
  end

  // Stall-cycle counter, free wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cyc <= '0;
    end else if (w_stall) begin
      r_stall_cyc <= r_stall_cyc + CYC_W'(1);
    end
  end

  assign stall_o      = w_stall;
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign refill_o     = r_refill;
  assign busy_o       = r_busy;
  assign miss_cnt_o   = r_miss_cnt;
  assign stall_cyc_o  = r_stall_cyc;

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_stall_ctrl
// Directed vector table, randomized run against a miss-plan queue model, and a
// saturation sequence on a narrow-counter instance.
// -----------------------------------------------------------------------------
module tb_dcache_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        req;
  logic        hit;
  logic        dirty;
  logic        ack;

  logic        stall, men, mwr, rfl, bsy;
  logic [15:0] mcnt;
  logic [31:0] scyc;

  logic        stall2, men2, mwr2, rfl2, bsy2;
  logic [1:0]  mcnt2;
  logic [31:0] scyc2;

  int unsigned total = 0;
  int unsigned bad   = 0;

  dcache_stall_ctrl #(.MISS_CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_req_i(req), .hit_i(hit),
    .dirty_i(dirty), .mem_ack_i(ack), .stall_o(stall), .mem_enable_o(men),
    .mem_write_o(mwr), .refill_o(rfl), .busy_o(bsy), .miss_cnt_o(mcnt),
    .stall_cyc_o(scyc)
  );

  dcache_stall_ctrl #(.MISS_CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_req_i(req), .hit_i(hit),
    .dirty_i(dirty), .mem_ack_i(ack), .stall_o(stall2), .mem_enable_o(men2),
    .mem_write_o(mwr2), .refill_o(rfl2), .busy_o(bsy2), .miss_cnt_o(mcnt2),
    .stall_cyc_o(scyc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, req, hit, dirty, ack;
    logic        st, en, wr, rf, bz;
    int unsigned mc;
    int unsigned sc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic s, input logic q,
                              input logic h, input logic d, input logic a,
                              input logic st, input logic en, input logic wr,
                              input logic rf, input logic bz,
                              input int unsigned mc, input int unsigned sc);
    vec_t v;
    v.rst = r; v.start = s; v.req = q; v.hit = h; v.dirty = d; v.ack = a;
    v.st = st; v.en = en; v.wr = wr; v.rf = rf; v.bz = bz; v.mc = mc; v.sc = sc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of remaining phases of the miss in flight
  // (1 = write-back, 2 = line read, 3 = commit). Empty queue means idle.
  int          plan[$];
  int unsigned m_mc;
  logic [31:0] m_sc;
  logic        e_st, e_en, e_wr, e_rf, e_bz;

  function automatic void model_eval();
    logic idle;
    idle = (plan.size() == 0);
    e_st = !idle || (start && req && !hit);
    e_en = !idle && (plan[0] != 3);
    e_wr = !idle && (plan[0] == 1);
    e_rf = !idle && (plan[0] == 3);
    e_bz = !idle;
  endfunction

  function automatic void model_edge();
    logic idle;
    idle = (plan.size() == 0);
    model_eval();
    if (rst) begin
      plan.delete();
      m_mc = 0;
      m_sc = 32'd0;
    end else begin
      if (e_st) m_sc = m_sc + 32'd1;
      if (idle) begin
        if (start && req && !hit) begin
          if (dirty) plan.push_back(1);
          plan.push_back(2);
          plan.push_back(3);
          m_mc = (m_mc < 65535) ? m_mc + 1 : 65535;
        end
      end else if (plan[0] == 3 || ack) begin
        void'(plan.pop_front());
      end
    end
  endfunction

  task automatic drive(input logic r, input logic s, input logic q,
                       input logic h, input logic d, input logic a);
    @(negedge clk);
    rst = r; start = s; req = q; hit = h; dirty = d; ack = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; req = 1'b0; hit = 1'b0; dirty = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    plan.delete(); m_mc = 0; m_sc = 32'd0;

    // Reset state with nothing presented.
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0);
    // Hit stream, 10 cycles.
    for (int i = 0; i < 10; i++) add(0,1,1,1,0,0, 0,0,0,0,0, 0,0);
    // Clean miss, ack in 2nd REFILL cycle, re-presented as hit.
    add(0,1,1,0,0,0, 1,0,0,0,0, 0,0);
    add(0,1,1,0,0,0, 1,1,0,0,1, 1,1);
    add(0,1,1,0,0,1, 1,1,0,0,1, 1,2);
    add(0,1,1,0,0,0, 1,0,0,1,1, 1,3);
    add(0,1,1,1,0,0, 0,0,0,0,0, 1,4);
    // Dirty miss, ack already high on WRITEBACK and REFILL entry.
    add(0,1,1,0,1,1, 1,0,0,0,0, 1,4);
    add(0,1,1,0,1,1, 1,1,1,0,1, 2,5);
    add(0,1,1,0,0,1, 1,1,0,0,1, 2,6);
    add(0,1,1,0,0,1, 1,0,0,1,1, 2,7);
    add(0,1,1,1,0,0, 0,0,0,0,0, 2,8);
    // start_i=0 blocks a miss.
    add(0,0,1,0,0,0, 0,0,0,0,0, 2,8);
    add(0,0,1,0,1,1, 0,0,0,0,0, 2,8);
    // start_i dropped mid-REFILL: sequence still completes.
    add(0,1,1,0,0,0, 1,0,0,0,0, 2,8);
    add(0,0,1,0,0,0, 1,1,0,0,1, 3,9);
    add(0,0,1,0,0,1, 1,1,0,0,1, 3,10);
    add(0,0,1,0,0,0, 1,0,0,1,1, 3,11);
    add(0,0,1,0,0,0, 0,0,0,0,0, 3,12);
    // Reset in the 2nd REFILL cycle: back to IDLE, no refill strobe.
    add(0,1,1,0,0,0, 1,0,0,0,0, 3,12);
    add(0,1,1,0,0,0, 1,1,0,0,1, 4,13);
    add(1,1,1,0,0,0, 1,1,0,0,1, 4,14);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0);
    // Ack in IDLE ignored.
    add(0,1,0,0,0,1, 0,0,0,0,0, 0,0);
    add(0,1,0,0,1,1, 0,0,0,0,0, 0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].req, tbl[i].hit, tbl[i].dirty, tbl[i].ack);
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("vec%0d.mem_enable", i), 32'(men), 32'(tbl[i].en));
      chk($sformatf("vec%0d.mem_write", i), 32'(mwr), 32'(tbl[i].wr));
      chk($sformatf("vec%0d.refill", i), 32'(rfl), 32'(tbl[i].rf));
      chk($sformatf("vec%0d.busy", i), 32'(bsy), 32'(tbl[i].bz));
      chk($sformatf("vec%0d.miss_cnt", i), 32'(mcnt), tbl[i].mc);
      chk($sformatf("vec%0d.stall_cyc", i), scyc, tbl[i].sc);
      model_edge();
    end

    // Randomized run against the plan-queue model.
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_eval();
      chk("rnd.stall", 32'(stall), 32'(e_st));
      chk("rnd.mem_enable", 32'(men), 32'(e_en));
      chk("rnd.mem_write", 32'(mwr), 32'(e_wr));
      chk("rnd.refill", 32'(rfl), 32'(e_rf));
      chk("rnd.busy", 32'(bsy), 32'(e_bz));
      chk("rnd.miss_cnt", 32'(mcnt), m_mc);
      chk("rnd.stall_cyc", scyc, m_sc);
      model_edge();
    end

    // Narrow counter saturation: 5 back-to-back clean misses, ack always high.
    drive(1,0,0,0,0,0);
    for (int k = 0; k < 5; k++) begin
      drive(0,1,1,0,0,1);
      chk($sformatf("sat%0d.idle_cnt", k), 32'(mcnt2), (k < 3) ? k : 3);
      chk($sformatf("sat%0d.stall", k), 32'(stall2), 32'd1);
      drive(0,1,1,0,0,1);
      chk($sformatf("sat%0d.miss_cnt", k), 32'(mcnt2), (k + 1 < 3) ? k + 1 : 3);
      drive(0,1,1,0,0,1);
      chk($sformatf("sat%0d.refill", k), 32'(rfl2), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_stall_ctrl.md
DCACHE_STALL_CTRL -- requirements
Module: dcache_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter: MISS_CNT_W, default 16, width of the saturating miss counter.
REQ-003 The ports SHALL be exactly:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  CPU run enable; when 0, no new miss is accepted.
- mem_req_i  input  1  MEM stage holds a valid load/store this cycle.
- hit_i  input  1  data cache tag hit for the MEM-stage address.
- dirty_i  input  1  victim line is dirty; sampled only in IDLE on a miss.
- mem_ack_i  input  1  main memory completed the current transaction.
- stall_o  output  1  freeze for PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- mem_enable_o  output  1  main-memory request valid.
- mem_write_o  output  1  1 = victim write-back, 0 = line read.
- refill_o  output  1  one-cycle strobe: write the fetched line into the cache.
- busy_o  output  1  FSM not in IDLE.
- miss_cnt_o  output  MISS_CNT_W  accepted misses, saturating.
- stall_cyc_o  output  32  cycles with stall_o=1, wrapping.

Function
REQ-004 The FSM SHALL have four states: IDLE, WRITEBACK, REFILL, COMMIT.
REQ-005 A miss is defined as start_i=1 and mem_req_i=1 and hit_i=0 while in IDLE.
REQ-006 IDLE on miss: next state WRITEBACK if dirty_i=1, else REFILL; otherwise remain in IDLE.
REQ-007 WRITEBACK: mem_enable_o=1 and mem_write_o=1; on mem_ack_i=1, next state REFILL; otherwise hold.
REQ-008 REFILL: mem_enable_o=1 and mem_write_o=0; on mem_ack_i=1, next state COMMIT; otherwise hold.
REQ-009 COMMIT: refill_o=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-010 mem_enable_o, mem_write_o, refill_o and busy_o SHALL be decoded from the current state only (Moore); all are 0 in IDLE.
REQ-011 stall_o SHALL be 1 in WRITEBACK, REFILL and COMMIT, and 1 combinationally in IDLE during a miss cycle (Mealy), so the pipeline registers do not advance on the detecting edge.
REQ-012 stall_o SHALL be 0 in IDLE when no miss is present, including when start_i=0.
REQ-013 On the cycle after COMMIT, the MEM-stage access is re-presented in IDLE; hit_i=1 gives stall_o=0.
REQ-014 mem_enable_o SHALL stay continuously high from WRITEBACK entry until the REFILL ack, with no idle gap between the write-back and the read.
REQ-015 mem_ack_i SHALL be ignored in IDLE and COMMIT.
REQ-016 start_i falling to 0 mid-miss SHALL NOT abort the sequence; it only blocks new misses.
REQ-017 miss_cnt_o SHALL increment by 1 on each IDLE->WRITEBACK or IDLE->REFILL transition and hold at all-ones.
REQ-018 stall_cyc_o SHALL increment on every rising edge where stall_o=1 and wrap from 0xFFFFFFFF to 0.
REQ-019 A miss with mem_ack_i already 1 on FSM entry SHALL still spend at least one cycle in each visited state.
REQ-020 Minimum clean-miss stall is 3 cycles: the IDLE miss cycle, 1 REFILL cycle and 1 COMMIT cycle.

Reset
REQ-021 rst_i=1 at a rising edge SHALL force state IDLE and clear miss_cnt_o and stall_cyc_o; all 1-bit outputs are then 0, given no miss is presented.
REQ-022 Reset SHALL take priority over every other event, including mid-WRITEBACK or mid-REFILL; no refill_o strobe is emitted for the aborted miss.

Verification
REQ-023 Hit stream: start_i=1, mem_req_i=1, hit_i=1 for 10 cycles -> stall_o=0 throughout, miss_cnt_o=0, stall_cyc_o=0.
REQ-024 Clean miss with ack 2 cycles after REFILL entry -> stall_o high for 4 cycles, refill_o pulses once, mem_write_o=0 throughout, miss_cnt_o=1, stall_cyc_o=4.
REQ-025 Dirty miss with ack after 1 cycle in WRITEBACK and 1 cycle in REFILL -> mem_enable_o high for 2 contiguous cycles, mem_write_o=1 then 0, COMMIT follows, stall_cyc_o=4.
REQ-026 Reset asserted in the 2nd REFILL cycle -> next cycle IDLE, all 1-bit outputs 0, counters 0, no refill_o pulse.
REQ-027 start_i=0 with mem_req_i=1, hit_i=0 -> no state change and stall_o=0; start_i dropped to 0 mid-REFILL -> sequence completes to IDLE.
REQ-028 With MISS_CNT_W=2, 5 back-to-back misses -> miss_cnt_o reads 1, 2, 3, 3, 3.
